// File: rtl/pin_entry_pkg.sv
// Shared types and key codes for the keypad PIN entry collector.
// Decoding is pure combinational; no state lives here.
package pin_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } pin_state_t;

  localparam logic [3:0] KEY_SUBMIT    = 4'd15;
  localparam logic [3:0] KEY_BACKSPACE = 4'd14;
  localparam logic [3:0] KEY_CLEAR     = 4'd10;

  typedef struct packed {
    logic       is_digit;
    logic       is_submit;
    logic       is_bksp;
    logic       is_clear;
    logic [3:0] digit;
  } key_t;

  // Codes 11..13 decode to no class at all and end up rejected.
  function automatic key_t decode_key(input logic [3:0] code);
    key_t k;
    k.is_digit  = (code <= 4'd9);
    k.is_submit = (code == KEY_SUBMIT);
    k.is_bksp   = (code == KEY_BACKSPACE);
    k.is_clear  = (code == KEY_CLEAR);
    k.digit     = code;
    return k;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts cycles while enabled; expired is high on the last count (TIMEOUT_CYCLES-1).
// Latency: expired is combinational from the count; no backpressure, clr wins over en.
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a held-off expiry cannot wrap into a second window.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/pin_entry_collector.sv
// Collects keypad digits into a PIN and hands it off with a pin_valid/pin_ready handshake.
// Key responses and timeout pulse one cycle after the key edge; HOLD stalls until pin_ready.
module pin_entry_collector
  import pin_entry_pkg::*;
#(
  parameter int MAX_DIGITS     = 8,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         tecla_value,
  input  logic                               tecla_valid,
  input  logic                               pin_ready,
  output logic [4*MAX_DIGITS-1:0]            pin_digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    pin_len,
  output logic                               pin_valid,
  output logic                               key_ack,
  output logic                               key_reject,
  output logic                               timeout
);

  localparam int LW = $clog2(MAX_DIGITS + 1);
  localparam int DW = 4 * MAX_DIGITS;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DIGITS);
  localparam logic [LW-1:0] MIN_LEN = LW'(MIN_DIGITS);
  localparam logic [LW-1:0] ONE     = LW'(1);

  pin_state_t    state;
  pin_state_t    state_nxt;
  logic          tecla_valid_q;
  logic          key_evt;
  key_t          key;
  logic          expired;
  logic          tmo_fire;
  logic          pin_take;
  logic          in_entry;
  logic          has_room;
  logic          can_submit;
  logic [DW-1:0] digits_nxt;
  logic [LW-1:0] len_nxt;
  logic          ack_d;
  logic          rej_d;
  logic          tmo_d;

  assign key_evt    = tecla_valid && !tecla_valid_q;
  assign key        = decode_key(tecla_value);
  assign in_entry   = (state == ST_ENTRY);
  assign has_room   = (pin_len < MAX_LEN);
  assign can_submit = (pin_len >= MIN_LEN);
  assign pin_valid  = (state == ST_HOLD);
  assign pin_take   = pin_valid && pin_ready;
  // A key arriving on the expiry cycle takes priority over the timeout.
  assign tmo_fire   = expired && !key_evt;

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (key_evt || tmo_fire),
    .en     (in_entry),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (key_evt) begin
          if (key.is_digit && has_room) begin
            state_nxt = ST_ENTRY;
          end else if (key.is_bksp && in_entry) begin
            state_nxt = (pin_len == ONE) ? ST_IDLE : ST_ENTRY;
          end else if (key.is_clear && in_entry) begin
            state_nxt = ST_IDLE;
          end else if (key.is_submit && can_submit) begin
            state_nxt = ST_HOLD;
          end
        end else if (tmo_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (pin_take) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    digits_nxt = pin_digits;
    len_nxt    = pin_len;
    ack_d      = 1'b0;
    rej_d      = 1'b0;
    tmo_d      = 1'b0;
    if (state == ST_HOLD) begin
      rej_d = key_evt;
      if (pin_take) begin
        digits_nxt = '0;
        len_nxt    = '0;
      end
    end else if (key_evt) begin
      if (key.is_digit) begin
        if (has_room) begin
          digits_nxt = (pin_digits << 4) | DW'(key.digit);
          len_nxt    = pin_len + ONE;
          ack_d      = 1'b1;
        end else begin
          rej_d = 1'b1;
        end
      end else if (key.is_bksp) begin
        if (in_entry) begin
          digits_nxt = pin_digits >> 4;
          len_nxt    = pin_len - ONE;
          ack_d      = 1'b1;
        end else begin
          rej_d = 1'b1;
        end
      end else if (key.is_clear) begin
        if (in_entry) begin
          digits_nxt = '0;
          len_nxt    = '0;
          ack_d      = 1'b1;
        end else begin
          rej_d = 1'b1;
        end
      end else if (key.is_submit) begin
        ack_d = can_submit;
        rej_d = !can_submit;
      end else begin
        rej_d = 1'b1;
      end
    end else if (tmo_fire) begin
      digits_nxt = '0;
      len_nxt    = '0;
      tmo_d      = 1'b1;
    end
  end

  // Reset leaves tecla_valid_q high so a key held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tecla_valid_q <= 1'b1;
      pin_digits    <= '0;
      pin_len       <= '0;
      key_ack       <= 1'b0;
      key_reject    <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      tecla_valid_q <= tecla_valid;
      pin_digits    <= digits_nxt;
      pin_len       <= len_nxt;
      key_ack       <= ack_d;
      key_reject    <= rej_d;
      timeout       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed and random keypad traffic against a queue-based model of the PIN entry rules.
module tb_pin_entry_collector;

  localparam int MAXD = 8;
  localparam int MIND = 4;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  tecla_value;
  logic        tecla_valid;
  logic        pin_ready;
  logic [31:0] pin_digits;
  logic [3:0]  pin_len;
  logic        pin_valid;
  logic        key_ack;
  logic        key_reject;
  logic        timeout;

  always #5 clk = ~clk;

  pin_entry_collector #(
    .MAX_DIGITS(MAXD),
    .MIN_DIGITS(MIND),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tecla_value(tecla_value),
    .tecla_valid(tecla_valid),
    .pin_ready  (pin_ready),
    .pin_digits (pin_digits),
    .pin_len    (pin_len),
    .pin_valid  (pin_valid),
    .key_ack    (key_ack),
    .key_reject (key_reject),
    .timeout    (timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: digits as a queue (oldest first), a hold flag, and the
  // edge index of the last key press for the inactivity rule.
  int   m_q[$];
  bit   m_hold;
  bit   tv_prev;
  int   edge_n;
  int   last_evt;
  bit   e_ack, e_rej, e_tmo;

  int   acc, r, code, gap, hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_digits();
    logic [31:0] d = '0;
    foreach (m_q[i]) d = (d << 4) | 32'(m_q[i]);
    return d;
  endfunction

  task automatic model_step(input bit evt, input int c, input bit rdy);
    e_ack = 0; e_rej = 0; e_tmo = 0;
    if (evt) last_evt = edge_n;
    if (m_hold) begin
      e_rej = evt;
      if (rdy) begin
        m_hold = 0;
        m_q.delete();
      end
    end else if (evt) begin
      if (c <= 9) begin
        if (m_q.size() < MAXD) begin m_q.push_back(c); e_ack = 1; end
        else e_rej = 1;
      end else if (c == 14) begin
        if (m_q.size() > 0) begin void'(m_q.pop_back()); e_ack = 1; end
        else e_rej = 1;
      end else if (c == 10) begin
        if (m_q.size() > 0) begin m_q.delete(); e_ack = 1; end
        else e_rej = 1;
      end else if (c == 15) begin
        if (m_q.size() >= MIND) begin m_hold = 1; e_ack = 1; end
        else e_rej = 1;
      end else begin
        e_rej = 1;
      end
    end else if (m_q.size() > 0 && (edge_n - last_evt) == TMO) begin
      m_q.delete();
      e_tmo = 1;
    end
  endtask

  // One clock: predict, advance the DUT, then compare every output.
  task automatic tick();
    bit evt;
    evt = tecla_valid && !tv_prev;
    tv_prev = tecla_valid;
    if (reset) begin
      m_q.delete();
      m_hold = 0;
      tv_prev = 1;
      e_ack = 0; e_rej = 0; e_tmo = 0;
    end else begin
      model_step(evt, int'(tecla_value), pin_ready);
    end
    @(posedge clk);
    #1;
    edge_n++;
    check("key_ack", key_ack, e_ack);
    check("key_reject", key_reject, e_rej);
    check("timeout", timeout, e_tmo);
    check("pin_valid", pin_valid, m_hold);
    check("pin_len", pin_len, m_q.size());
    check("pin_digits", pin_digits, model_digits());
  endtask

  task automatic key_down(input int c);
    tecla_value = 4'(c);
    tecla_valid = 1'b1;
    tick();
  endtask

  task automatic key_up();
    tecla_valid = 1'b0;
    tick();
  endtask

  task automatic key(input int c);
    key_down(c);
    key_up();
  endtask

  initial begin
    edge_n = 0; last_evt = -1000; m_hold = 0; tv_prev = 1;
    reset = 1'b1; tecla_valid = 1'b0; tecla_value = 4'd0; pin_ready = 1'b1;
    tick();
    tick();
    check("rst_len", pin_len, 0);
    check("rst_valid", pin_valid, 0);
    reset = 1'b0;
    tick();

    // 1,2,3,4,SUBMIT with consumer ready
    acc = 0;
    for (int i = 1; i <= 4; i++) begin key_down(i); acc += key_ack; key_up(); end
    key_down(15);
    acc += key_ack;
    check("ack_x5", acc, 5);
    check("hold_valid", pin_valid, 1);
    check("hold_1234", pin_digits[15:0], 16'h1234);
    check("hold_len4", pin_len, 4);
    key_up();
    check("released", pin_valid, 0);

    // backspace editing, then short submit
    key(5); key(6); key(14); key(7); key(8); key(9);
    key_down(15);
    check("edit_5789", pin_digits[15:0], 16'h5789);
    check("edit_len", pin_len, 4);
    key_up();
    key(5); key(6);
    key_down(15);
    check("short_rej", key_reject, 1);
    check("short_len", pin_len, 2);
    key_up();
    key(10);

    // overflow at MAX_DIGITS, then clear
    for (int i = 1; i <= 8; i++) key(i);
    key_down(9);
    check("ovf_rej", key_reject, 1);
    check("ovf_len", pin_len, 8);
    check("ovf_data", pin_digits, 32'h12345678);
    key_up();
    key_down(10);
    check("clr_ack", key_ack, 1);
    check("clr_len", pin_len, 0);
    key_up();

    // long hold is one event; key held through reset is none
    key_down(3);
    acc = key_ack;
    repeat (99) begin tick(); acc += key_ack; end
    check("held_one_ack", acc, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    acc = 0;
    repeat (10) begin tick(); acc += key_ack + key_reject; end
    check("held_rst_noevt", acc, 0);
    key_up();

    // inactivity timeout: 20 cycles after key_ack
    key_down(7);
    check("tmo_ack", key_ack, 1);
    key_up();
    repeat (18) tick();
    check("tmo_early", timeout, 0);
    tick();
    check("tmo_fire", timeout, 1);
    check("tmo_len", pin_len, 0);
    key_down(7); key_up();
    repeat (18) tick();
    key_down(8);
    check("tmo_race_ack", key_ack, 1);
    check("tmo_race_notmo", timeout, 0);
    check("tmo_race_len", pin_len, 2);
    key_up();
    key(10);

    // HOLD with consumer stalled
    pin_ready = 1'b0;
    key(1); key(2); key(3); key(4); key(15);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      key_down(i); acc += key_reject; key_up(); acc += key_reject;
      repeat (8) tick();
    end
    check("stall_rejects", acc, 5);
    check("stall_valid", pin_valid, 1);
    check("stall_data", pin_digits[15:0], 16'h1234);
    pin_ready = 1'b1;
    tick();
    check("stall_release", pin_valid, 0);

    // reset abandons a held PIN
    pin_ready = 1'b0;
    key(4); key(3); key(2); key(1); key(15);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_hold_valid", pin_valid, 0);
    tick();

    // random traffic against the model
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin reset = 1'b1; tick(); reset = 1'b0; end
      r = $urandom_range(0, 19);
      if (r < 12)      code = $urandom_range(0, 9);
      else if (r < 15) code = 15;
      else if (r < 17) code = 14;
      else if (r < 18) code = 10;
      else if (r < 19) code = $urandom_range(11, 13);
      else             code = $urandom_range(0, 15);
      tecla_value = 4'(code);
      tecla_valid = 1'b1;
      hold = $urandom_range(1, 3);
      repeat (hold) begin pin_ready = ($urandom_range(0, 3) == 0); tick(); end
      tecla_valid = 1'b0;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 4);
      repeat (gap) begin pin_ready = ($urandom_range(0, 3) == 0); tick(); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_entry_collector.md
PIN_ENTRY_COLLECTOR -- requirements
Module: pin_entry_collector

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, maximum PIN length in digits.
REQ-002 SHALL have parameter MIN_DIGITS, default 4, minimum length accepted on submit.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000, clock cycles of inactivity before the entry is discarded.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tecla_value  input  4  key code from the keypad decoder.
REQ-007 SHALL have port tecla_valid  input  1  level; high from key acceptance until release.
REQ-008 SHALL have port pin_ready  input  1  consumer accepts the PIN when high with pin_valid.
REQ-009 SHALL have port pin_digits  output  4*MAX_DIGITS  digits as 4-bit values, newest in [3:0], unused upper nibbles zero.
REQ-010 SHALL have port pin_len  output  $clog2(MAX_DIGITS+1)  number of digits held.
REQ-011 SHALL have port pin_valid  output  1  submitted PIN available.
REQ-012 SHALL have port key_ack  output  1  one-cycle pulse per accepted key.
REQ-013 SHALL have port key_reject  output  1  one-cycle pulse per rejected key.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when the entry is discarded for inactivity.

Function
REQ-015 SHALL form key_evt = tecla_valid AND NOT tecla_valid_q; a held key yields exactly one event.
REQ-016 SHALL decode codes 0-9 as digit, 15 as SUBMIT, 14 as BACKSPACE, 10 as CLEAR; codes 11-13 SHALL produce key_reject.
REQ-017 SHALL implement states IDLE (pin_len=0), ENTRY (pin_len>0, editing), HOLD (pin_valid=1).
REQ-018 Digit in IDLE/ENTRY with pin_len<MAX_DIGITS: pin_digits <= {pin_digits<<4 | digit}, pin_len+1, key_ack, state ENTRY.
REQ-019 Digit with pin_len=MAX_DIGITS: contents unchanged, key_reject.
REQ-020 BACKSPACE in ENTRY: pin_digits >> 4, pin_len-1, key_ack; go to IDLE if pin_len reaches 0.
REQ-021 CLEAR in ENTRY: pin_digits=0, pin_len=0, key_ack, go to IDLE.
REQ-022 BACKSPACE or CLEAR in IDLE: no change, key_reject.
REQ-023 SUBMIT with pin_len>=MIN_DIGITS: key_ack, go to HOLD; pin_valid high on the next cycle.
REQ-024 SUBMIT with pin_len<MIN_DIGITS (including IDLE): contents kept, key_reject.
REQ-025 In HOLD: pin_digits and pin_len stable; every key_evt produces key_reject with no state change.
REQ-026 In HOLD: on pin_valid AND pin_ready, clear buffer and length and go to IDLE; pin_valid low on the next cycle.
REQ-027 Inactivity counter SHALL clear on any key_evt, count only in ENTRY, and freeze in IDLE and HOLD.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 in ENTRY with no key_evt that cycle: clear buffer, pulse timeout, go to IDLE.
REQ-029 A key_evt coinciding with expiry SHALL win: the key is processed and the counter clears.
REQ-030 key_ack, key_reject and timeout SHALL be mutually exclusive and registered, asserting the cycle after the causing event.

Reset
REQ-031 Reset SHALL set state IDLE, pin_digits 0, pin_len 0, pin_valid 0, key_ack 0, key_reject 0, timeout 0, and counter 0.
REQ-032 Reset SHALL set tecla_valid_q to 1, so a key held through reset produces no event.
REQ-033 Reset asserted during HOLD SHALL abandon the PIN; pin_valid is low the cycle after reset.

Structure
REQ-034 Package pin_entry_pkg SHALL hold the state enum and the constants KEY_SUBMIT=15, KEY_BACKSPACE=14, KEY_CLEAR=10.
REQ-035 The inactivity counter SHALL be sub-module inactivity_timer (inputs clr, en; output expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-036 Keys 1,2,3,4,SUBMIT, pin_ready=1 -> key_ack x5; pin_valid one cycle with pin_digits[15:0]=16'h1234 and pin_len=4; then IDLE.
REQ-037 Keys 5,6,BACKSPACE,7,8,9,SUBMIT -> pin_digits[15:0]=16'h5789, pin_len=4; SUBMIT after only 5,6 -> key_reject and pin_len stays 2.
REQ-038 Nine digits with MAX_DIGITS=8 -> ninth gives key_reject, pin_len=8; CLEAR -> pin_len=0 and key_ack.
REQ-039 tecla_valid held high 100 cycles -> exactly one key_ack; held through reset deassert -> no event.
REQ-040 TIMEOUT_CYCLES=20: one digit then idle -> timeout pulse 20 cycles after the key's key_ack, pin_len=0; a key on the expiry cycle -> no timeout pulse.
REQ-041 HOLD with pin_ready=0 for 50 cycles plus key presses -> pin_valid stays high, data stable, key_reject per key; pin_ready=1 -> release.
